i2c_slave: RTL and testbench
============================

I2C_SLAVE -- requirements
Module: i2c_slave

Interface
REQ-001 SHALL have parameter Address, default 7'b0101010, meaning the 7-bit target address the block responds to.
REQ-002 SHALL have parameter MaxBytesToReceive, default 2, meaning the capacity of the receive buffer in bytes.
REQ-003 SHALL have parameter MaxBytesToSend, default 2, meaning the capacity of the transmit buffer in bytes.
REQ-004 SHALL have port clock, input, 1 bit: system clock, at least 10x the SCL frequency (24 MHz nominal).
REQ-005 SHALL have port reset, input, 1 bit: reset, synchronous and active-low.
REQ-006 SHALL have port sda, inout, 1 bit: open-drain data; the block only drives 0 or z.
REQ-007 SHALL have port scl, input, 1 bit: bus clock (no clock stretching).
REQ-008 SHALL have port nrOfBytesToReceive, input, $clog2(MaxBytesToReceive+1) bits: number of write bytes to ACK.
REQ-009 SHALL have port bytesReceived, output, [MaxBytesToReceive][8] bits: received bytes, index 0 is the first byte.
REQ-010 SHALL have port nrOfBytesToSend, input, $clog2(MaxBytesToSend+1) bits: number of valid read bytes.
REQ-011 SHALL have port bytesToSend, input, [MaxBytesToSend][8] bits: read data, index 0 sent first, MSB first.
REQ-012 SHALL have ports startReceived, restartReceived, stopReceived, output, 1 bit each: one-clock event pulses.
REQ-013 SHALL have ports addressedForReceive, addressedForSend, output, 1 bit each: one-clock pulses on an address match (R/W=0 / R/W=1).
REQ-014 SHALL have port receivedCount, output, $clog2(MaxBytesToReceive+1) bits: bytes ACKed in the current transfer.

Function
REQ-015 SHALL pass scl and sda through 2-flop synchronizers; edges SHALL be detected from the synchronized current and previous values (3-clock pin-to-event latency).
REQ-016 SHALL detect START as synchronized sda falling while scl is high, and STOP as sda rising while scl high; both SHALL be detected in any state.
REQ-017 SHALL pulse startReceived on START from IDLE, restartReceived on START from any other state, and stopReceived on STOP.
REQ-018 SHALL implement states IDLE, ADDRESS, ADDR_ACK, RX_BYTE, RX_ACK, TX_BYTE, TX_ACK, IGNORE; START goes to ADDRESS, STOP goes to IDLE.
REQ-019 SHALL sample data bits on the scl rising edge and change the sda drive only one clock after a detected scl falling edge.
REQ-020 ADDRESS SHALL shift in 8 bits; on a match it goes to ADDR_ACK (drives 0 for the 9th clock) and pulses addressedForReceive or addressedForSend; on a mismatch it goes to IGNORE with sda released.
REQ-021 After ADDR_ACK, SHALL go to RX_BYTE if R/W=0, or to TX_BYTE if R/W=1, clearing the byte index and receivedCount.
REQ-022 RX_BYTE SHALL store byte n into bytesReceived[n] and ACK only if n < nrOfBytesToReceive; otherwise it SHALL NACK, leave the buffer unchanged and go to IGNORE.
REQ-023 TX_BYTE SHALL drive bytesToSend[n] bit-by-bit, releasing sda for 1-bits; for n >= nrOfBytesToSend it SHALL send 0xFF.
REQ-024 TX_ACK SHALL release sda and sample the master ACK; ACK (0) goes to the next TX_BYTE, NACK (1) goes to IGNORE.
REQ-025 IGNORE SHALL keep sda released until START or STOP.
REQ-026 SHALL keep bytesReceived stable between transfers and update it only on a completed ACKed byte.
REQ-027 START during any byte SHALL abort that byte without storing it.

Reset
REQ-028 While reset=0 at a clock edge, the block SHALL enter IDLE, release sda, clear the synchronizers to 1, clear all pulses, receivedCount and bytesReceived to 0; this SHALL also hold mid-transfer.

Structure
REQ-029 SHALL put the state enum and the address/data width constants in package i2c_pkg.
REQ-030 SHALL put the synchronizer plus edge/START/STOP detector in sub-module i2c_line_monitor.

Verification
REQ-031 Write 0x2A+W, 0x1C, 0x33, STOP -> 3 ACKs, bytesReceived[0]=0x1C, [1]=0x33, receivedCount=2, addressedForReceive and stopReceived pulse once each.
REQ-032 Address 0x2B+W -> 9th bit sda=1 (released), no addressed pulses, bytesReceived unchanged.
REQ-033 Read 0x2A+R with bytesToSend[0]=0x1C, [1]=0x33, master ACK then NACK -> sda carries 0x1C then 0x33, then stays released until STOP.
REQ-034 Write 0x2A+W, 0x55, Sr, 0x2A+R -> restartReceived pulses once, addressedForSend pulses once, first read byte is bytesToSend[0].
REQ-035 nrOfBytesToReceive=1, write 0xAA, 0xBB -> 0xAA ACKed, 0xBB NACKed, bytesReceived[1] unchanged, receivedCount=1.
REQ-036 reset=0 during bit 4 of a read byte -> sda released on the next clock, state IDLE, then the next START+address is ACKed normally.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared I2C target definitions: bus field widths and the protocol state encoding.
package i2c_pkg;
    localparam int ADDR_W = 7;
    localparam int DATA_W = 8;
    localparam int IDX_W  = 8;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ADDRESS  = 3'd1,
        ADDR_ACK = 3'd2,
        RX_BYTE  = 3'd3,
        RX_ACK   = 3'd4,
        TX_BYTE  = 3'd5,
        TX_ACK   = 3'd6,
        IGNORE   = 3'd7
    } i2c_state_e;
endpackage

// File: rtl/i2c_line_monitor.sv
// Synchronizes the raw SCL/SDA pins and derives SCL edges plus START/STOP conditions.
module i2c_line_monitor (
    input  logic clock,
    input  logic reset,
    input  logic scl_i,
    input  logic sda_i,
    output logic sda_o,
    output logic scl_rise_o,
    output logic scl_fall_o,
    output logic start_o,
    output logic stop_o
);
    logic [1:0] scl_sync_q;
    logic [1:0] sda_sync_q;
    logic       scl_prev_q;
    logic       sda_prev_q;

    // Two-flop synchronizers plus one history flop per line; idle bus level is high.
    always_ff @(posedge clock) begin
        if (!reset) begin
            scl_sync_q <= 2'b11;
            sda_sync_q <= 2'b11;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[0], scl_i};
            sda_sync_q <= {sda_sync_q[0], sda_i};
            scl_prev_q <= scl_sync_q[1];
            sda_prev_q <= sda_sync_q[1];
        end
    end

    assign sda_o      = sda_sync_q[1];
    assign scl_rise_o = scl_sync_q[1] & ~scl_prev_q;
    assign scl_fall_o = ~scl_sync_q[1] & scl_prev_q;
    assign start_o    = scl_sync_q[1] & scl_prev_q & sda_prev_q & ~sda_sync_q[1];
    assign stop_o     = scl_sync_q[1] & scl_prev_q & ~sda_prev_q & sda_sync_q[1];
endmodule

// File: rtl/i2c_slave.sv
// I2C target with a fixed 7-bit address, a small receive buffer and a transmit table.
module i2c_slave
    import i2c_pkg::*;
#(
    parameter logic [ADDR_W-1:0] Address = 7'b0101010,
    parameter int MaxBytesToReceive = 2,
    parameter int MaxBytesToSend    = 2,
    localparam int RCW = $clog2(MaxBytesToReceive + 1),
    localparam int SCW = $clog2(MaxBytesToSend + 1)
) (
    input  logic                                     clock,
    input  logic                                     reset,
    inout  wire                                      sda,
    input  logic                                     scl,
    input  logic [RCW-1:0]                           nrOfBytesToReceive,
    output logic [MaxBytesToReceive-1:0][DATA_W-1:0] bytesReceived,
    input  logic [SCW-1:0]                           nrOfBytesToSend,
    input  logic [MaxBytesToSend-1:0][DATA_W-1:0]    bytesToSend,
    output logic                                     startReceived,
    output logic                                     restartReceived,
    output logic                                     stopReceived,
    output logic                                     addressedForReceive,
    output logic                                     addressedForSend,
    output logic [RCW-1:0]                           receivedCount
);
    i2c_state_e state_q, state_d;
    logic [3:0]        bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [DATA_W-1:0] tx_q, tx_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              rw_q, rw_d;
    logic              ack_q, ack_d;
    logic              sda_oe_q, sda_oe_d;
    logic [RCW-1:0]    rcnt_q, rcnt_d;
    logic [MaxBytesToReceive-1:0][DATA_W-1:0] rx_buf_q, rx_buf_d;
    logic start_q, start_d, restart_q, restart_d, stop_q, stop_d;
    logic addr_rx_q, addr_rx_d, addr_tx_q, addr_tx_d;

    logic sda_s, scl_rise_s, scl_fall_s, start_s, stop_s;
    logic [IDX_W-1:0]  idx_inc_s, tx_idx_s, nr_rx_ext_s, nr_tx_ext_s;
    logic [DATA_W-1:0] tx_sel_s;
    logic              rx_fit_s;

    i2c_line_monitor u_mon (
        .clock      (clock),
        .reset      (reset),
        .scl_i      (scl),
        .sda_i      (sda),
        .sda_o      (sda_s),
        .scl_rise_o (scl_rise_s),
        .scl_fall_o (scl_fall_s),
        .start_o    (start_s),
        .stop_o     (stop_s)
    );

    assign idx_inc_s   = (idx_q == 8'hFF) ? idx_q : idx_q + 8'd1;
    assign tx_idx_s    = (state_q == TX_ACK) ? idx_inc_s : 8'd0;
    assign nr_rx_ext_s = {{(IDX_W-RCW){1'b0}}, nrOfBytesToReceive};
    assign nr_tx_ext_s = {{(IDX_W-SCW){1'b0}}, nrOfBytesToSend};

    // Next transmit byte; indices beyond the valid count read as all ones.
    always_comb begin
        tx_sel_s = 8'hFF;
        for (int i = 0; i < MaxBytesToSend; i++) begin
            if ((tx_idx_s == i[IDX_W-1:0]) && (tx_idx_s < nr_tx_ext_s)) begin
                tx_sel_s = bytesToSend[i];
            end else begin
                tx_sel_s = tx_sel_s;
            end
        end
    end

    // Whether the current receive index has a slot in the buffer.
    always_comb begin
        rx_fit_s = 1'b0;
        for (int i = 0; i < MaxBytesToReceive; i++) begin
            if (idx_q == i[IDX_W-1:0]) begin
                rx_fit_s = 1'b1;
            end else begin
                rx_fit_s = rx_fit_s;
            end
        end
    end

    // Protocol FSM: bits sampled on SCL rise, state advances on SCL fall.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        tx_d      = tx_q;
        idx_d     = idx_q;
        rw_d      = rw_q;
        ack_d     = ack_q;
        rcnt_d    = rcnt_q;
        rx_buf_d  = rx_buf_q;
        start_d   = 1'b0;
        restart_d = 1'b0;
        stop_d    = 1'b0;
        addr_rx_d = 1'b0;
        addr_tx_d = 1'b0;

        // The drive follows the registered state, so it lags the SCL fall by one clock.
        case (state_q)
            ADDR_ACK: sda_oe_d = 1'b1;
            RX_ACK:   sda_oe_d = 1'b1;
            TX_BYTE:  sda_oe_d = ~tx_q[DATA_W-1];
            default:  sda_oe_d = 1'b0;
        endcase

        if (start_s) begin
            start_d   = (state_q == IDLE);
            restart_d = (state_q != IDLE);
            state_d   = ADDRESS;
            bit_cnt_d = 4'd0;
            shift_d   = 8'h00;
        end else if (stop_s) begin
            stop_d  = 1'b1;
            state_d = IDLE;
        end else begin
            case (state_q)
                ADDRESS, RX_BYTE: begin
                    if (scl_rise_s) begin
                        shift_d   = {shift_q[DATA_W-2:0], sda_s};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall_s && (bit_cnt_q == 4'd8)) begin
                        if (state_q == ADDRESS) begin
                            rw_d = shift_q[0];
                            if (shift_q[DATA_W-1:1] == Address) begin
                                state_d   = ADDR_ACK;
                                addr_rx_d = ~shift_q[0];
                                addr_tx_d = shift_q[0];
                            end else begin
                                state_d = IGNORE;
                            end
                        end else if ((idx_q < nr_rx_ext_s) && rx_fit_s) begin
                            state_d = RX_ACK;
                            rcnt_d  = rcnt_q + RCW'(1'b1);
                            for (int i = 0; i < MaxBytesToReceive; i++) begin
                                if (idx_q == i[IDX_W-1:0]) begin
                                    rx_buf_d[i] = shift_q;
                                end else begin
                                    rx_buf_d[i] = rx_buf_q[i];
                                end
                            end
                        end else begin
                            state_d = IGNORE;
                        end
                    end else begin
                        state_d = state_q;
                    end
                end
                ADDR_ACK: begin
                    if (scl_fall_s) begin
                        idx_d     = 8'd0;
                        rcnt_d    = '0;
                        bit_cnt_d = 4'd0;
                        tx_d      = tx_sel_s;
                        state_d   = rw_q ? TX_BYTE : RX_BYTE;
                    end else begin
                        state_d = state_q;
                    end
                end
                RX_ACK: begin
                    if (scl_fall_s) begin
                        idx_d     = idx_inc_s;
                        bit_cnt_d = 4'd0;
                        state_d   = RX_BYTE;
                    end else begin
                        state_d = state_q;
                    end
                end
                TX_BYTE: begin
                    if (scl_rise_s) begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall_s && (bit_cnt_q == 4'd8)) begin
                        state_d = TX_ACK;
                    end else if (scl_fall_s) begin
                        tx_d = {tx_q[DATA_W-2:0], 1'b1};
                    end else begin
                        state_d = state_q;
                    end
                end
                TX_ACK: begin
                    if (scl_rise_s) begin
                        ack_d = sda_s;
                    end else if (scl_fall_s && !ack_q) begin
                        idx_d     = idx_inc_s;
                        tx_d      = tx_sel_s;
                        bit_cnt_d = 4'd0;
                        state_d   = TX_BYTE;
                    end else if (scl_fall_s) begin
                        state_d = IGNORE;
                    end else begin
                        state_d = state_q;
                    end
                end
                IDLE:    state_d = IDLE;
                IGNORE:  state_d = IGNORE;
                default: state_d = IDLE;
            endcase
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q   <= IDLE;
            bit_cnt_q <= 4'd0;
            shift_q   <= 8'h00;
            tx_q      <= 8'hFF;
            idx_q     <= 8'd0;
            rw_q      <= 1'b0;
            ack_q     <= 1'b1;
            sda_oe_q  <= 1'b0;
            rcnt_q    <= '0;
            rx_buf_q  <= '0;
            start_q   <= 1'b0;
            restart_q <= 1'b0;
            stop_q    <= 1'b0;
            addr_rx_q <= 1'b0;
            addr_tx_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
            idx_q     <= idx_d;
            rw_q      <= rw_d;
            ack_q     <= ack_d;
            sda_oe_q  <= sda_oe_d;
            rcnt_q    <= rcnt_d;
            rx_buf_q  <= rx_buf_d;
            start_q   <= start_d;
            restart_q <= restart_d;
            stop_q    <= stop_d;
            addr_rx_q <= addr_rx_d;
            addr_tx_q <= addr_tx_d;
        end
    end

    assign sda                 = sda_oe_q ? 1'b0 : 1'bz;
    assign bytesReceived       = rx_buf_q;
    assign receivedCount       = rcnt_q;
    assign startReceived       = start_q;
    assign restartReceived     = restart_q;
    assign stopReceived        = stop_q;
    assign addressedForReceive = addr_rx_q;
    assign addressedForSend    = addr_tx_q;
endmodule

// File: tb/tb_i2c_slave.sv
// Directed bench: a bit-banged I2C master exercises writes, reads, restart, NACK and reset.
module tb_i2c_slave;
    import i2c_pkg::*;

    logic clock = 1'b0;
    logic reset;
    logic scl_drv;
    logic sda_low;
    wire  sda;
    logic [1:0]      nr_rx, nr_tx, rcnt;
    logic [1:0][7:0] bytes_rx, bytes_tx;
    logic start_p, restart_p, stop_p, arx_p, atx_p;

    int checks = 0;
    int errors = 0;
    int n_start = 0, n_restart = 0, n_stop = 0, n_arx = 0, n_atx = 0;
    int b_start, b_restart, b_stop, b_arx, b_atx;
    logic       ack;
    logic [7:0] rd;
    logic       bit_v;

    always #5 clock = ~clock;

    pullup (sda);
    assign sda = sda_low ? 1'b0 : 1'bz;

    i2c_slave dut (
        .clock               (clock),
        .reset               (reset),
        .sda                 (sda),
        .scl                 (scl_drv),
        .nrOfBytesToReceive  (nr_rx),
        .bytesReceived       (bytes_rx),
        .nrOfBytesToSend     (nr_tx),
        .bytesToSend         (bytes_tx),
        .startReceived       (start_p),
        .restartReceived     (restart_p),
        .stopReceived        (stop_p),
        .addressedForReceive (arx_p),
        .addressedForSend    (atx_p),
        .receivedCount       (rcnt)
    );

    always @(posedge clock) begin
        if (start_p)   n_start   <= n_start + 1;
        if (restart_p) n_restart <= n_restart + 1;
        if (stop_p)    n_stop    <= n_stop + 1;
        if (arx_p)     n_arx     <= n_arx + 1;
        if (atx_p)     n_atx     <= n_atx + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic snap();
        b_start = n_start; b_restart = n_restart; b_stop = n_stop;
        b_arx = n_arx; b_atx = n_atx;
    endtask

    task automatic start_cond();
        tick(5); sda_low = 1'b0; tick(15); scl_drv = 1'b1; tick(20);
        sda_low = 1'b1; tick(20); scl_drv = 1'b0;
    endtask

    task automatic stop_cond();
        tick(5); sda_low = 1'b1; tick(15); scl_drv = 1'b1; tick(20);
        sda_low = 1'b0; tick(20);
    endtask

    task automatic write_bit(input logic b);
        tick(5); sda_low = ~b; tick(15); scl_drv = 1'b1; tick(20); scl_drv = 1'b0;
    endtask

    task automatic read_bit(output logic b);
        tick(5); sda_low = 1'b0; tick(15); scl_drv = 1'b1; tick(10);
        b = sda; tick(10); scl_drv = 1'b0;
    endtask

    task automatic write_byte(input logic [7:0] d, output logic a);
        for (int i = 7; i >= 0; i--) write_bit(d[i]);
        read_bit(a);
    endtask

    task automatic read_byte(input logic a, output logic [7:0] d);
        for (int i = 7; i >= 0; i--) read_bit(d[i]);
        write_bit(a);
    endtask

    initial begin
        reset    = 1'b0;
        scl_drv  = 1'b1;
        sda_low  = 1'b0;
        nr_rx    = 2'd2;
        nr_tx    = 2'd2;
        bytes_tx = {8'h33, 8'h1C};
        tick(5);
        check("rst_sda", 32'(sda), 32'h1);
        check("rst_rcnt", 32'(rcnt), 32'h0);
        check("rst_buf", 32'(bytes_rx), 32'h0);
        check("rst_state", 32'(dut.state_q), 32'(IDLE));
        reset = 1'b1;
        tick(5);

        // Write 0x2A+W, 0x1C, 0x33, STOP
        snap();
        start_cond();
        write_byte(8'h54, ack); check("wr_addr_ack", 32'(ack), 32'h0);
        write_byte(8'h1C, ack); check("wr_b0_ack", 32'(ack), 32'h0);
        write_byte(8'h33, ack); check("wr_b1_ack", 32'(ack), 32'h0);
        stop_cond();
        check("wr_buf0", 32'(bytes_rx[0]), 32'h1C);
        check("wr_buf1", 32'(bytes_rx[1]), 32'h33);
        check("wr_rcnt", 32'(rcnt), 32'h2);
        check("wr_start", 32'(n_start - b_start), 32'h1);
        check("wr_arx", 32'(n_arx - b_arx), 32'h1);
        check("wr_stop", 32'(n_stop - b_stop), 32'h1);

        // Foreign address 0x2B+W
        snap();
        start_cond();
        write_byte(8'h56, ack); check("bad_addr_nack", 32'(ack), 32'h1);
        write_byte(8'h77, ack); check("bad_data_nack", 32'(ack), 32'h1);
        stop_cond();
        check("bad_arx", 32'(n_arx - b_arx), 32'h0);
        check("bad_atx", 32'(n_atx - b_atx), 32'h0);
        check("bad_buf", 32'(bytes_rx), 32'h331C);

        // Read 0x2A+R: ACK then NACK, then the bus stays released
        snap();
        start_cond();
        write_byte(8'h55, ack); check("rd_addr_ack", 32'(ack), 32'h0);
        read_byte(1'b0, rd); check("rd_b0", 32'(rd), 32'h1C);
        read_byte(1'b1, rd); check("rd_b1", 32'(rd), 32'h33);
        read_byte(1'b1, rd); check("rd_released", 32'(rd), 32'hFF);
        stop_cond();
        check("rd_atx", 32'(n_atx - b_atx), 32'h1);

        // Write 0x55 then repeated START into a read
        snap();
        start_cond();
        write_byte(8'h54, ack); check("sr_waddr_ack", 32'(ack), 32'h0);
        write_byte(8'h55, ack); check("sr_data_ack", 32'(ack), 32'h0);
        start_cond();
        write_byte(8'h55, ack); check("sr_raddr_ack", 32'(ack), 32'h0);
        read_byte(1'b1, rd); check("sr_rd_b0", 32'(rd), 32'h1C);
        stop_cond();
        check("sr_restart", 32'(n_restart - b_restart), 32'h1);
        check("sr_start", 32'(n_start - b_start), 32'h1);
        check("sr_atx", 32'(n_atx - b_atx), 32'h1);
        check("sr_buf0", 32'(bytes_rx[0]), 32'h55);

        // Receive limit of one byte
        nr_rx = 2'd1;
        start_cond();
        write_byte(8'h54, ack); check("lim_addr_ack", 32'(ack), 32'h0);
        write_byte(8'hAA, ack); check("lim_b0_ack", 32'(ack), 32'h0);
        write_byte(8'hBB, ack); check("lim_b1_nack", 32'(ack), 32'h1);
        stop_cond();
        check("lim_buf0", 32'(bytes_rx[0]), 32'hAA);
        check("lim_buf1", 32'(bytes_rx[1]), 32'h33);
        check("lim_rcnt", 32'(rcnt), 32'h1);

        // Reset in the middle of bit 4 of a read byte of zeros
        bytes_tx = 16'h0000;
        start_cond();
        write_byte(8'h55, ack); check("mid_addr_ack", 32'(ack), 32'h0);
        for (int i = 0; i < 3; i++) read_bit(bit_v);
        tick(5); sda_low = 1'b0; tick(15); scl_drv = 1'b1; tick(10);
        check("mid_driven", 32'(sda), 32'h0);
        reset = 1'b0;
        tick(1);
        check("mid_sda_rel", 32'(sda), 32'h1);
        check("mid_state", 32'(dut.state_q), 32'(IDLE));
        check("mid_buf", 32'(bytes_rx), 32'h0);
        tick(2);
        reset = 1'b1;
        tick(5); scl_drv = 1'b0; tick(20);
        snap();
        start_cond();
        write_byte(8'h54, ack); check("post_addr_ack", 32'(ack), 32'h0);
        stop_cond();
        check("post_start", 32'(n_start - b_start), 32'h1);
        check("post_arx", 32'(n_arx - b_arx), 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
